dense_seq_engine: RTL and testbench



---
 rtl/dense_pkg.sv | 22 ++
 rtl/dense_mac.sv | 43 ++++
 rtl/dense_seq_engine.sv | 182 ++++++++++++++++++
 tb/tb_dense_seq_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the dense layer engine: controller state encoding and
// a constant log2 helper used to size address and index fields.
package dense_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_ADD   = 3'd4,
        S_DRAIN = 3'd5
    } state_e;

    // Ceiling log2, never below 1 so single-entry fields still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dense_mac.sv
// Signed multiply-accumulate register: clr_i zeroes the accumulator, en_i adds
// the sign-extended product a_i*b_i. Sums wrap modulo 2^ACC_W.
module dense_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dense_seq_engine.sv
// Sequential dense layer: buffers one input vector, computes each neuron as a
// dot product plus bias using external memories, then streams the results.
// Build option: DENSE_RELU_EN clamps stored results at zero.
module dense_seq_engine
    import dense_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 10,
    localparam int WA_W = clog2(IN_LEN * OUT_LEN),
    localparam int BA_W = clog2(OUT_LEN),
    localparam int IW   = clog2(IN_LEN),
    localparam int CW   = clog2(IN_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     w_rd,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     b_rd,
    output logic [BA_W-1:0]          b_addr,
    input  logic signed [ACC_W-1:0]  b_data,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done
);

    function automatic logic signed [ACC_W-1:0] activate(input logic signed [ACC_W-1:0] x);
`ifdef DENSE_RELU_EN
        return x[ACC_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    state_e                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [BA_W-1:0]          o_q, o_d;
    logic [BA_W-1:0]          k_q, k_d;
    logic [CW-1:0]            c_q, c_d;
    logic signed [DATA_W-1:0] in_buf_q  [IN_LEN];
    logic signed [ACC_W-1:0]  out_buf_q [OUT_LEN];

    logic                     mac_clr, mac_en, in_we, out_we;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [ACC_W-1:0]  acc, result;

    // Weight w_data answers the read issued at c-1, so pair it with in_buf[c-1].
    assign mac_a  = in_buf_q[IW'(c_q - CW'(1))];
    assign result = activate(acc + b_data);
    assign busy   = (state_q != S_IDLE);

    dense_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr_i(mac_clr),
        .en_i (mac_en),
        .a_i  (mac_a),
        .b_i  (w_data),
        .acc_o(acc)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        o_d       = o_q;
        k_d       = k_q;
        c_d       = c_q;
        in_ready  = 1'b0;
        w_rd      = 1'b0;
        w_addr    = '0;
        b_rd      = 1'b0;
        b_addr    = '0;
        out_valid = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        in_we     = 1'b0;
        out_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    i_d     = '0;
                    o_d     = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_we = 1'b1;
                    i_d   = i_q + IW'(1);
                    if (i_q == IW'(IN_LEN - 1)) begin
                        state_d = S_MAC;
                        c_d     = '0;
                        mac_clr = 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (c_q < CW'(IN_LEN)) begin
                    w_rd   = 1'b1;
                    w_addr = WA_W'(o_q) * WA_W'(IN_LEN) + WA_W'(c_q);
                end
                mac_en = (c_q != '0);
                if (c_q == CW'(IN_LEN)) begin
                    state_d = S_BIAS;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_BIAS: begin
                b_rd    = 1'b1;
                b_addr  = o_q;
                state_d = S_ADD;
            end
            S_ADD: begin
                out_we = 1'b1;
                if (o_q == BA_W'(OUT_LEN - 1)) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    o_d     = o_q + BA_W'(1);
                    c_d     = '0;
                    mac_clr = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = out_buf_q[k_q];
                if (out_ready) begin
                    if (k_q == BA_W'(OUT_LEN - 1)) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k_q + BA_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            o_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            k_q     <= k_d;
            c_q     <= c_d;
        end
    end

    // Buffers carry no reset: they are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (in_we) begin
            in_buf_q[i_q] <= in_data;
        end
        if (out_we) begin
            out_buf_q[o_q] <= result;
        end
    end

endmodule

// File: tb/tb_dense_seq_engine.sv
// Directed bench for dense_seq_engine with IN_LEN=4, OUT_LEN=2 and a one-cycle
// latency weight/bias memory model.
module tb_dense_seq_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic signed [7:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               w_rd;
    logic [2:0]         w_addr;
    logic signed [7:0]  w_data = '0;
    logic               b_rd;
    logic [0:0]         b_addr;
    logic signed [23:0] b_data = '0;
    logic signed [23:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               done;

    dense_seq_engine #(
        .DATA_W (8),
        .ACC_W  (24),
        .IN_LEN (4),
        .OUT_LEN(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_rd     (w_rd),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_rd     (b_rd),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic signed [7:0]  w_mem [8];
    logic signed [23:0] b_mem [2];

    always @(posedge clk) begin
        if (w_rd) w_data <= w_mem[w_addr];
        if (b_rd) b_data <= b_mem[b_addr];
    end

    int checks = 0;
    int passed = 0;

    logic signed [7:0]  vin [4];
    logic [2:0]         wseq [8];
    logic [0:0]         bseq [2];
    int                 wn, bn, lat, ndone;
    logic signed [23:0] res [2];
    logic signed [23:0] hold;
    logic               stall_bad, gap_bad;

    function automatic logic signed [23:0] act(input logic signed [23:0] x);
`ifdef DENSE_RELU_EN
        return (x < 0) ? 24'sd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_inputs(input int gap_at);
        gap_bad = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == gap_at) begin
                in_valid = 1'b0;
                repeat (3) begin
                    tick();
                    if (w_rd !== 1'b0 || in_ready !== 1'b1) gap_bad = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_data  = vin[j];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_compute();
        lat = -1;
        wn  = 0;
        bn  = 0;
        for (int t = 0; t < 100; t++) begin
            if (out_valid === 1'b1) begin
                lat = t;
                break;
            end
            if (w_rd === 1'b1) begin
                if (wn < 8) wseq[wn] = w_addr;
                wn++;
            end
            if (b_rd === 1'b1) begin
                if (bn < 2) bseq[bn] = b_addr;
                bn++;
            end
            tick();
        end
    endtask

    task automatic drain(input int stall_at);
        ndone     = 0;
        stall_bad = 1'b0;
        hold      = '0;
        for (int k = 0; k < 2; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                #1;
                hold = out_data;
                repeat (5) begin
                    tick();
                    if (out_data !== hold || out_valid !== 1'b1 || done !== 1'b0) stall_bad = 1'b1;
                end
            end
            out_ready = 1'b1;
            #1;
            res[k] = out_data;
            if (done === 1'b1) ndone++;
            tick();
        end
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        checks++;
        if (w_rd !== 1'b0) $display("FAIL reset_w_rd got %0b want 0", w_rd); else passed++;
        checks++;
        if (b_rd !== 1'b0) $display("FAIL reset_b_rd got %0b want 0", b_rd); else passed++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
        checks++;
        if (w_addr !== 3'd0) $display("FAIL reset_w_addr got %0d want 0", w_addr); else passed++;
        checks++;
        if (b_addr !== 1'd0) $display("FAIL reset_b_addr got %0d want 0", b_addr); else passed++;
        checks++;
        if (out_data !== 24'sd0) $display("FAIL reset_out_data got %0d want 0", out_data); else passed++;
        checks++;
        rst = 1'b1;
        tick();
        if (busy !== 1'b0) $display("FAIL idle_after_reset busy got %0b want 0", busy); else passed++;
        checks++;
    endtask

    task automatic test_basic();
        vin   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        b_mem = '{24'sd0, -24'sd5};
        do_start();
        load_inputs(-1);
        run_compute();
        if (lat !== 14) $display("FAIL basic_latency got %0d want 14", lat); else passed++;
        checks++;
        if (wn !== 8) $display("FAIL basic_w_rd_count got %0d want 8", wn); else passed++;
        checks++;
        for (int j = 0; j < 8; j++) begin
            if (wseq[j] !== 3'(j)) $display("FAIL basic_w_addr[%0d] got %0d want %0d", j, wseq[j], j); else passed++;
            checks++;
        end
        if (bn !== 2) $display("FAIL basic_b_rd_count got %0d want 2", bn); else passed++;
        checks++;
        if (bseq[0] !== 1'd0 || bseq[1] !== 1'd1)
            $display("FAIL basic_b_addr got %0d,%0d want 0,1", bseq[0], bseq[1]);
        else passed++;
        checks++;
        drain(-1);
        if (res[0] !== 24'sd10) $display("FAIL basic_out0 got %0d want 10", res[0]); else passed++;
        checks++;
        if (res[1] !== 24'sd5) $display("FAIL basic_out1 got %0d want 5", res[1]); else passed++;
        checks++;
        if (ndone !== 1) $display("FAIL basic_done_pulses got %0d want 1", ndone); else passed++;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle got busy=%0b done=%0b want 0,0", busy, done); else passed++;
        checks++;
    endtask

    task automatic test_negative();
        vin   = '{-8'sd1, -8'sd1, -8'sd1, -8'sd1};
        w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        b_mem = '{24'sd0, -24'sd5};
        do_start();
        load_inputs(-1);
        run_compute();
        drain(-1);
        if (res[0] !== act(-24'sd4)) $display("FAIL neg_out0 got %0d want %0d", res[0], act(-24'sd4)); else passed++;
        checks++;
        if (res[1] !== act(-24'sd9)) $display("FAIL neg_out1 got %0d want %0d", res[1], act(-24'sd9)); else passed++;
        checks++;
    endtask

    task automatic test_stall();
        vin   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        w_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, 8'sd0, 8'sd2, 8'sd1};
        b_mem = '{24'sd0, -24'sd5};
        do_start();
        load_inputs(-1);
        run_compute();
        drain(0);
        if (hold !== 24'sd30) $display("FAIL stall_held_value got %0d want 30", hold); else passed++;
        checks++;
        if (stall_bad !== 1'b0) $display("FAIL stall_stable got %0b want 0", stall_bad); else passed++;
        checks++;
        if (res[0] !== 24'sd30) $display("FAIL stall_out0 got %0d want 30", res[0]); else passed++;
        checks++;
        if (res[1] !== 24'sd4) $display("FAIL stall_out1 got %0d want 4", res[1]); else passed++;
        checks++;
        if (ndone !== 1) $display("FAIL stall_done_pulses got %0d want 1", ndone); else passed++;
        checks++;
    endtask

    task automatic test_gap();
        vin   = '{8'sd5, -8'sd3, 8'sd7, 8'sd2};
        w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd3};
        b_mem = '{24'sd0, -24'sd5};
        do_start();
        load_inputs(3);
        if (gap_bad !== 1'b0) $display("FAIL gap_stays_in_load got %0b want 0", gap_bad); else passed++;
        checks++;
        if (w_rd !== 1'b1 || w_addr !== 3'd0) $display("FAIL gap_mac_entry got w_rd=%0b w_addr=%0d want 1,0", w_rd, w_addr); else passed++;
        checks++;
        run_compute();
        if (lat !== 14) $display("FAIL gap_latency got %0d want 14", lat); else passed++;
        checks++;
        drain(-1);
        if (res[0] !== 24'sd11) $display("FAIL gap_out0 got %0d want 11", res[0]); else passed++;
        checks++;
        if (res[1] !== 24'sd14) $display("FAIL gap_out1 got %0d want 14", res[1]); else passed++;
        checks++;
    endtask

    task automatic test_reset_midrun();
        logic found;
        vin   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        b_mem = '{24'sd0, -24'sd5};
        found = 1'b0;
        do_start();
        load_inputs(-1);
        for (int t = 0; t < 30; t++) begin
            if (w_rd === 1'b1 && w_addr === 3'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (found !== 1'b1) $display("FAIL midrun_reach_neuron1 got %0b want 1", found); else passed++;
        checks++;
        rst = 1'b0;
        #1;
        if (busy !== 1'b0) $display("FAIL midrun_busy got %0b want 0", busy); else passed++;
        checks++;
        if (w_rd !== 1'b0 || w_addr !== 3'd0) $display("FAIL midrun_w got w_rd=%0b w_addr=%0d want 0,0", w_rd, w_addr); else passed++;
        checks++;
        if (b_rd !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL midrun_ctrl got b_rd=%0b out_valid=%0b in_ready=%0b done=%0b want 0", b_rd, out_valid, in_ready, done);
        else passed++;
        checks++;
        tick();
        rst = 1'b1;
        tick();
        do_start();
        load_inputs(-1);
        run_compute();
        drain(-1);
        if (res[0] !== 24'sd10) $display("FAIL midrun_rerun_out0 got %0d want 10", res[0]); else passed++;
        checks++;
        if (res[1] !== 24'sd5) $display("FAIL midrun_rerun_out1 got %0d want 5", res[1]); else passed++;
        checks++;
    endtask

    task automatic test_back_to_back();
        vin   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        b_mem = '{24'sd0, -24'sd5};
        do_start();
        load_inputs(-1);
        start = 1'b1;
        run_compute();
        start = 1'b0;
        if (lat !== 14) $display("FAIL b2b_latency_with_start got %0d want 14", lat); else passed++;
        checks++;
        drain(-1);
        if (res[0] !== 24'sd10 || res[1] !== 24'sd5) $display("FAIL b2b_first_run got %0d,%0d want 10,5", res[0], res[1]); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_after_done got %0b want 0", busy); else passed++;
        checks++;
        w_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, 8'sd0, 8'sd2, 8'sd1};
        do_start();
        if (in_ready !== 1'b1) $display("FAIL b2b_restart_load got %0b want 1", in_ready); else passed++;
        checks++;
        load_inputs(-1);
        run_compute();
        drain(-1);
        if (res[0] !== 24'sd30) $display("FAIL b2b_out0 got %0d want 30", res[0]); else passed++;
        checks++;
        if (res[1] !== 24'sd4) $display("FAIL b2b_out1 got %0d want 4", res[1]); else passed++;
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_stall();
        test_gap();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
